// File: rtl/fmul_pipe.sv
// fmul_pipe: parametrised IEEE-754 multiplier with valid/ready flow control.
// The arithmetic is one combinational datapath feeding a STAGES-deep register
// chain. Register retiming in synthesis spreads the unpack, multiply and round
// logic across the chain, so the result is the same for every legal depth.
module fmul_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     op1,
    input  logic [EXP_W+MAN_W:0]     op2,
    input  logic [1:0]               opc,
    input  logic [1:0]               r_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] C_BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] C_EMAX = XW'((1 << EXP_W) - 1);

    // ---------------- unpack and classify ----------------
    logic [DW-1:0]    w_b;
    logic             w_sa, w_sb, w_sign;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_a_zero, w_a_inf, w_a_nan, w_a_snan;
    logic             w_b_zero, w_b_inf, w_b_nan, w_b_snan;
    logic             w_inf_zero;

    // A*A reuses op1 as the second operand
    assign w_b = (opc == 2'b11) ? op1 : op2;
    assign {w_sa, w_ea, w_ma} = op1;
    assign {w_sb, w_eb, w_mb} = w_b;

    // subnormals have a zero exponent field and therefore classify as zero
    assign w_a_zero   = (w_ea == '0);
    assign w_a_inf    = (w_ea == '1) && (w_ma == '0);
    assign w_a_nan    = (w_ea == '1) && (w_ma != '0);
    assign w_a_snan   = w_a_nan && !w_ma[MAN_W-1];
    assign w_b_zero   = (w_eb == '0);
    assign w_b_inf    = (w_eb == '1) && (w_mb == '0);
    assign w_b_nan    = (w_eb == '1) && (w_mb != '0);
    assign w_b_snan   = w_b_nan && !w_mb[MAN_W-1];
    assign w_inf_zero = (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf);

    // result sign from operand signs, then negate or clear according to opc
    always_comb begin
        w_sign = w_sa ^ w_sb;
        case (opc)
            2'b01:   w_sign = ~(w_sa ^ w_sb);
            2'b10:   w_sign = 1'b0;
            default: w_sign = w_sa ^ w_sb;
        endcase
    end

    // ---------------- exponent sum and mantissa product ----------------
    logic signed [XW-1:0] w_exp_sum, w_exp_n, w_exp_r;
    logic [PW-1:0]        w_prod;
    logic                 w_hi, w_guard, w_sticky, w_inc, w_inexact;
    logic [MAN_W-1:0]     w_man_n;
    logic [MAN_W:0]       w_man_r;
    logic                 w_ovf, w_unf;

    assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - C_BIAS;
    assign w_prod    = PW'({1'b1, w_ma}) * PW'({1'b1, w_mb});

    // product lies in [1,4); a set top bit means shift right by one
    assign w_hi     = w_prod[PW-1];
    assign w_man_n  = w_hi ? w_prod[PW-2 -: MAN_W] : w_prod[PW-3 -: MAN_W];
    assign w_guard  = w_hi ? w_prod[PW-2-MAN_W] : w_prod[PW-3-MAN_W];
    assign w_sticky = w_hi ? (|w_prod[PW-3-MAN_W:0]) : (|w_prod[PW-4-MAN_W:0]);
    assign w_exp_n  = w_exp_sum + $signed({{(XW-1){1'b0}}, w_hi});

    // round-increment decision for the selected rounding mode
    always_comb begin
        w_inc = 1'b0;
        case (r_mode)
            2'b00:   w_inc = w_guard && (w_sticky || w_man_n[0]);
            2'b01:   w_inc = 1'b0;
            2'b10:   w_inc = (w_guard || w_sticky) && w_sign;
            default: w_inc = (w_guard || w_sticky) && !w_sign;
        endcase
    end

    // a carry out of the mantissa leaves it all-zero and bumps the exponent
    assign w_man_r   = {1'b0, w_man_n} + {{MAN_W{1'b0}}, w_inc};
    assign w_exp_r   = w_exp_n + $signed({{(XW-1){1'b0}}, w_man_r[MAN_W]});
    assign w_inexact = w_guard || w_sticky;
    assign w_ovf     = (w_exp_r >= C_EMAX);
    assign w_unf     = w_exp_r[XW-1] || (w_exp_r == '0);

    // ---------------- final result selection ----------------
    logic [DW-1:0] w_res;
    logic [3:0]    w_flg;

    // specials first, then overflow/underflow, otherwise the rounded normal
    always_comb begin
        w_res = {w_sign, w_exp_r[EXP_W-1:0], w_man_r[MAN_W-1:0]};
        w_flg = {3'b000, w_inexact};
        if (w_a_nan || w_b_nan || w_inf_zero) begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flg = {w_a_snan || w_b_snan || w_inf_zero, 3'b000};
        end else if (w_a_inf || w_b_inf) begin
            w_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 4'b0000;
        end else if (w_a_zero || w_b_zero) begin
            w_res = {w_sign, {(DW-1){1'b0}}};
            w_flg = 4'b0000;
        end else if (w_ovf) begin
            w_flg = 4'b0101;
            if ((r_mode == 2'b00) || ((r_mode == 2'b11) && !w_sign) ||
                ((r_mode == 2'b10) && w_sign))
                w_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else
                w_res = {w_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else if (w_unf) begin
            w_flg = 4'b0011;
            if (((r_mode == 2'b11) && !w_sign) || ((r_mode == 2'b10) && w_sign))
                w_res = {w_sign, {(EXP_W-1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
            else
                w_res = {w_sign, {(DW-1){1'b0}}};
        end
    end

    // ---------------- register chain with global stall ----------------
    logic w_advance;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             r_vld;
            logic [DW-1:0]    r_res;
            logic [3:0]       r_flg;
            logic [TAG_W-1:0] r_tag;
            logic             w_vld_in;
            logic [DW-1:0]    w_res_in;
            logic [3:0]       w_flg_in;
            logic [TAG_W-1:0] w_tag_in;

            if (gi == 0) begin : g_first
                assign w_vld_in = in_valid;
                assign w_res_in = w_res;
                assign w_flg_in = w_flg;
                assign w_tag_in = in_tag;
            end else begin : g_next
                assign w_vld_in = g_stage[gi-1].r_vld;
                assign w_res_in = g_stage[gi-1].r_res;
                assign w_flg_in = g_stage[gi-1].r_flg;
                assign w_tag_in = g_stage[gi-1].r_tag;
            end

            // every stage moves together; bubbles advance like real entries
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_res <= '0;
                    r_flg <= '0;
                    r_tag <= '0;
                end else if (w_advance) begin
                    r_vld <= w_vld_in;
                    r_res <= w_res_in;
                    r_flg <= w_flg_in;
                    r_tag <= w_tag_in;
                end
            end
        end
    endgenerate

    assign w_advance = !g_stage[STAGES-1].r_vld || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = g_stage[STAGES-1].r_vld;
    assign result    = g_stage[STAGES-1].r_res;
    assign flags     = g_stage[STAGES-1].r_flg;
    assign out_tag   = g_stage[STAGES-1].r_tag;

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed and randomized checks of fmul_pipe (FP32 build)
// against a value-level reference model and an in-order scoreboard.
module tb_fmul_pipe;
    localparam int STAGES = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [1:0]  opc = '0;
    logic [1:0]  r_mode = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [3:0]  out_tag;

    fmul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .opc(opc), .r_mode(r_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  oc;
        logic [1:0]  rm;
        logic [31:0] er;
        logic [3:0]  ef;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t dir_v [20];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product, rounded to 24 significant bits by
    // comparing the discarded remainder with one half-ulp.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b_in,
                                            input logic [1:0] oc, input logic [1:0] rm);
        logic [31:0] b;
        logic s, up;
        int ea, eb, e, n, sh;
        longint unsigned ma, mb, p, q, rem, half;
        logic az, bz, ai, bi, an, bn, asn, bsn;
        logic [3:0] fl;
        logic [31:0] r;
        b   = (oc == 2'd3) ? a : b_in;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        az  = (ea == 0);
        bz  = (eb == 0);
        ai  = (ea == 255) && (a[22:0] == 0);
        bi  = (eb == 255) && (b[22:0] == 0);
        an  = (ea == 255) && (a[22:0] != 0);
        bn  = (eb == 255) && (b[22:0] != 0);
        asn = an && !a[22];
        bsn = bn && !b[22];
        s = a[31] ^ b[31];
        if (oc == 2'd1) s = !s;
        else if (oc == 2'd2) s = 1'b0;
        if (an || bn || (ai && bz) || (az && bi))
            return {(asn || bsn || (ai && bz) || (az && bi)), 3'b000, 32'h7fc00000};
        if (ai || bi) return {4'b0000, s, 8'hff, 23'd0};
        if (az || bz) return {4'b0000, s, 31'd0};
        ma = 64'(a[22:0]) + (64'd1 << 23);
        mb = 64'(b[22:0]) + (64'd1 << 23);
        p  = ma * mb;
        n  = 0;
        for (int i = 0; i < 64; i++) if (p[i]) n = i + 1;
        sh   = n - 24;
        q    = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        e    = ea + eb - 127 + (n - 47);
        case (rm)
            2'd0:    up = (rem > half) || ((rem == half) && q[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = (rem != 0) && s;
            default: up = (rem != 0) && !s;
        endcase
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e++;
        end
        fl = {3'b000, rem != 0};
        if (e >= 255) begin
            fl = 4'b0101;
            if ((rm == 2'd0) || ((rm == 2'd3) && !s) || ((rm == 2'd2) && s))
                r = {s, 8'hff, 23'd0};
            else
                r = {s, 8'hfe, 23'h7fffff};
        end else if (e <= 0) begin
            fl = 4'b0011;
            if (((rm == 2'd3) && !s) || ((rm == 2'd2) && s)) r = {s, 8'h01, 23'd0};
            else r = {s, 31'd0};
        end else begin
            r = {s, e[7:0], q[22:0]};
        end
        return {fl, r};
    endfunction

    function automatic logic [31:0] rand_op();
        logic s;
        logic [7:0] e;
        logic [22:0] m;
        s = 1'($urandom);
        m = 23'($urandom);
        case ($urandom_range(0, 11))
            0:       e = 8'd0;
            1:       begin e = 8'hff; m = '0; end
            2:       begin e = 8'hff; m[22] = 1'b1; end
            3:       begin e = 8'hff; m[22] = 1'b0; m[0] = 1'b1; end
            4, 5:    e = 8'($urandom_range(190, 254));
            6, 7:    e = 8'($urandom_range(1, 64));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {s, e, m};
    endfunction

    // present one operation, wait (bounded) for acceptance, log its expectation
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] oc,
                        input logic [1:0] rm, input logic [3:0] tg,
                        input logic [31:0] er, input logic [3:0] ef);
        logic ok;
        exp_t e;
        op1 = a; op2 = b; opc = oc; r_mode = rm; in_tag = tg; in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            check_val("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.res = er; e.flg = ef; e.tag = tg;
            sb.push_back(e);
            n_acc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] a, input logic [31:0] b, input logic [1:0] oc,
                          input logic [1:0] rm, input logic [3:0] tg);
        logic [35:0] r;
        r = ref_mul(a, b, oc, rm);
        send(a, b, oc, rm, tg, r[31:0], r[35:32]);
    endtask

    task automatic lat_test(input vec_t v, input logic [3:0] tg);
        send(v.a, v.b, v.oc, v.rm, tg, v.er, v.ef);
        for (int k = 1; k <= STAGES; k++) begin
            @(negedge clk);
            check_val("latency_out_valid", 32'(out_valid), 32'(k == STAGES));
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        check_val("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // output monitor: one line per delivered result, checked in order
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("out tag=%0h res=%08h flags=%b", out_tag, result, flags);
                check_val("result", result, mon_e.res);
                check_val("flags", 32'(flags), 32'(mon_e.flg));
                check_val("tag", 32'(out_tag), 32'(mon_e.tag));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic        have, done;
        logic [31:0] cap_res;
        logic [3:0]  cap_tag;
        int          acc0;

        dir_v = '{
            '{32'h3f800000, 32'h40000000, 2'd0, 2'd0, 32'h40000000, 4'b0000},
            '{32'h3fc00000, 32'h3fc00000, 2'd0, 2'd0, 32'h40100000, 4'b0000},
            '{32'h3f800001, 32'h3f800001, 2'd0, 2'd0, 32'h3f800002, 4'b0001},
            '{32'h3f800001, 32'h3f800001, 2'd0, 2'd1, 32'h3f800002, 4'b0001},
            '{32'h3f800001, 32'h3f800001, 2'd0, 2'd3, 32'h3f800003, 4'b0001},
            '{32'h3f800001, 32'h3f800001, 2'd1, 2'd2, 32'hbf800003, 4'b0001},
            '{32'h7f7fffff, 32'h40000000, 2'd0, 2'd0, 32'h7f800000, 4'b0101},
            '{32'h7f7fffff, 32'h40000000, 2'd0, 2'd1, 32'h7f7fffff, 4'b0101},
            '{32'h7f800000, 32'h00000000, 2'd0, 2'd0, 32'h7fc00000, 4'b1000},
            '{32'h00800000, 32'h3f000000, 2'd0, 2'd0, 32'h00000000, 4'b0011},
            '{32'h00800000, 32'h3f000000, 2'd0, 2'd3, 32'h00800000, 4'b0011},
            '{32'hbf800000, 32'h40000000, 2'd2, 2'd0, 32'h40000000, 4'b0000},
            '{32'h40000000, 32'h12345678, 2'd3, 2'd0, 32'h40800000, 4'b0000},
            '{32'h7fc00000, 32'h3f800000, 2'd0, 2'd0, 32'h7fc00000, 4'b0000},
            '{32'h7f800001, 32'h3f800000, 2'd0, 2'd0, 32'h7fc00000, 4'b1000},
            '{32'h80800000, 32'h3f000000, 2'd0, 2'd2, 32'h80800000, 4'b0011},
            '{32'hff7fffff, 32'h40000000, 2'd0, 2'd3, 32'hff7fffff, 4'b0101},
            '{32'hff7fffff, 32'h40000000, 2'd0, 2'd2, 32'hff800000, 4'b0101},
            '{32'h7f800000, 32'hc0000000, 2'd0, 2'd0, 32'hff800000, 4'b0000},
            '{32'h80000000, 32'h40400000, 2'd0, 2'd0, 32'h80000000, 4'b0000}
        };

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_out_valid", 32'(out_valid), 32'd0);
        check_val("reset_result", result, 32'd0);
        check_val("reset_flags", 32'(flags), 32'd0);
        check_val("reset_out_tag", 32'(out_tag), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // directed vectors, first one with a latency check
        lat_test(dir_v[0], 4'd0);
        for (int i = 1; i < 20; i++)
            send(dir_v[i].a, dir_v[i].b, dir_v[i].oc, dir_v[i].rm, 4'(i),
                 dir_v[i].er, dir_v[i].ef);
        drain();

        // back-pressure: consumer stalled for 8 cycles, producer always valid
        out_ready = 1'b0;
        acc0 = n_acc;
        have = 1'b0;
        cap_res = '0;
        cap_tag = '0;
        fork
            begin
                for (int t = 1; t <= 5; t++)
                    send_m(rand_op(), rand_op(), 2'($urandom), 2'($urandom), 4'(t));
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (!have) begin
                            cap_res = result;
                            cap_tag = out_tag;
                            have = 1'b1;
                        end else begin
                            check_val("stall_result_stable", result, cap_res);
                            check_val("stall_tag_stable", 32'(out_tag), 32'(cap_tag));
                        end
                    end
                end
                check_val("stall_out_valid_seen", 32'(have), 32'd1);
                check_val("stall_accepted", 32'(n_acc - acc0), 32'd3);
                check_val("stall_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with three operations in flight
        for (int t = 0; t < 3; t++)
            send_m(rand_op(), rand_op(), 2'd0, 2'd0, 4'(10 + t));
        check_val("pre_reset_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("async_reset_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val("no_stale_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        lat_test(dir_v[1], 4'd7);
        drain();

        // randomized traffic with random back-pressure and input gaps
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk); #1;
                    end
                    send_m(rand_op(), rand_op(), 2'($urandom), 2'($urandom), 4'(i));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Parametrised, pipelined IEEE-754 floating-point multiplier. It is the successor to the fixed-format FMUL32.
- Adds generic exponent/mantissa widths, a configurable pipeline depth, valid/ready flow control with back-pressure, a pass-through tag, and IEEE exception flags.
- Sits between the operand-issue logic and the writeback arbiter. The C reference model (func_fmul_c) remains the golden model for the FP32 configuration.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa field width. Data width is 1+EXP_W+MAN_W (32 by default).
- STAGES, 3, pipeline register stages, legal range 1..4. Equals latency in cycles when there is no stall.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept this cycle
- op1  in  1+EXP_W+MAN_W  operand A
- op2  in  1+EXP_W+MAN_W  operand B
- opc  in  2  op select: 00 A*B, 01 -(A*B), 10 |A*B|, 11 A*A
- r_mode  in  2  rounding: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf)
- in_tag  in  TAG_W  sideband returned with result
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- result  out  1+EXP_W+MAN_W  rounded product
- flags  out  4  {invalid, overflow, underflow, inexact}
- out_tag  out  TAG_W  tag of the presented result

Behaviour:
- **Reset.** rst_n low asynchronously clears every stage valid bit.
  - out_valid=0, result=0, flags=0, out_tag=0.
  - in_ready=1 from the first cycle after rst_n rises.
  - Reset mid-operation discards all in-flight work. Nothing is emitted afterwards.
- **Handshake.**
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
  - The pipeline uses a global stall: advance = !out_valid || out_ready, and in_ready = advance.
  - While stalled, every stage holds its contents, and result/flags/out_tag are stable.
  - Bubbles do not collapse.
- **Latency.** The result of an operation accepted at cycle N appears at cycle N+STAGES when no stall occurs. Results come out in strict input order, at a throughput of 1 per cycle.
- **Suggested stage split for STAGES=3.**
  - S1: unpack, special-case detect, sign/exponent sum.
  - S2: (MAN_W+1)x(MAN_W+1) mantissa multiply.
  - S3: normalise, round, pack, flags.
  - Other depths re-time these functions, but the output must be identical.
- **Arithmetic.**
  - Sign = sA^sB, then modified by opc: 01 inverts the sign, 10 forces the sign to 0.
  - opc=11 ignores op2.
  - Exponent sum is computed with EXP_W+2 signed bits.
  - Normalise by 1 if the product is >=2. Rounding uses guard and sticky bits.
  - A mantissa carry-out on rounding increments the exponent.
- **Denormals.** Subnormal inputs are treated as signed zero.
  - A result below the minimum normal is flushed to signed zero with underflow=1 and inexact=1.
  - Exception: under RUP (positive result) or RDN (negative result), the result becomes the minimum normal with the same flags.
- **Overflow.** Sets overflow=1 and inexact=1. The result depends on rounding mode:
  - RNE → ±inf.
  - RTZ → ±max finite.
  - RUP → +inf or -max finite.
  - RDN → +max finite or -inf.
- **Specials.**
  - Any NaN operand, or inf*0, produces canonical qNaN (exp all-ones, MSB of mantissa set, sign 0).
  - invalid=1 for inf*0 or any sNaN. A qNaN operand raises no flags.
  - inf*finite-nonzero = signed inf, no flags.
  - Zero*finite = signed zero, no flags.
- **Flags.** Flags are per-operation, aligned with result, and not sticky.

Test Plan:
- 3f800000*40000000, opc=00, RNE → 40000000, flags 0, out_valid exactly 3 cycles after accept. 3fc00000*3fc00000 → 40100000.
- 3f800001*3f800001 → RNE 3f800002, RTZ 3f800002, RUP 3f800003; inexact=1 in all three cases. The same case with opc=01 and RDN → bf800003.
- 7f7fffff*40000000 → RNE 7f800000, RTZ 7f7fffff, flags 4'b0101. 7f800000*00000000 → 7fc00000, flags 4'b1000.
- 00800000*3f000000 → RNE 00000000, flags 4'b0011; RUP → 00800000, flags 4'b0011.
- STAGES=3, out_ready=0 for 8 cycles, in_valid held high with tags 1..5:
  - exactly 3 operations are accepted, then in_ready=0;
  - result and out_tag stay stable while stalled;
  - after out_ready=1, tags emerge in order 1..5 with no loss or duplication.
- Assert rst_n=0 with 3 operations in flight → out_valid=0 the same cycle. After release, no stale results appear, and a new operation completes with correct latency.
